// File: rtl/mult_pipe_vr.sv
// mult_pipe_vr -- pipelined WIDTH x WIDTH -> 2*WIDTH multiplier with a
// valid/ready handshake on both sides and a sideband tag per operation.
//
// Build option: define MULT_PIPE_VR_SIGNED_EN to honour in_signed
// (two's-complement multiply). Without it, in_signed is ignored and every
// operation is unsigned. The port list is the same in both builds.
//
// Ports:
//   clk, rst_n           clock, asynchronous active-low reset
//   in_valid/in_ready    operand handshake; accept when both are high
//   multiplicand         operand A (WIDTH)
//   multiplier           operand B (WIDTH)
//   in_signed            1 = signed multiply (only with the build option)
//   in_tag               sideband tag returned with the product (TAG_W)
//   out_valid/out_ready  result handshake
//   product              full 2*WIDTH product, 0 while out_valid=0
//   out_tag              tag of the presented product, 0 while out_valid=0
//   busy                 any pipeline stage holds a valid operation
//
// Stages 1..LAT-1 carry the operands; the last stage registers the product.
// The whole pipeline freezes when the last stage holds a result that the
// downstream does not take.
module mult_pipe_vr #(
  parameter int WIDTH = 32,
  parameter int LAT   = 2,
  parameter int TAG_W = 4
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [WIDTH-1:0]     multiplicand,
  input  logic [WIDTH-1:0]     multiplier,
  input  logic                 in_signed,
  input  logic [TAG_W-1:0]     in_tag,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [2*WIDTH-1:0]   product,
  output logic [TAG_W-1:0]     out_tag,
  output logic                 busy
);

  localparam int unsigned OPS = LAT - 1;  // number of operand-carrying stages

  logic [LAT-1:0]     vld_q, vld_d;
  logic [WIDTH-1:0]   a_q   [OPS];
  logic [WIDTH-1:0]   a_d   [OPS];
  logic [WIDTH-1:0]   b_q   [OPS];
  logic [WIDTH-1:0]   b_d   [OPS];
  logic               sgn_q [OPS];
  logic               sgn_d [OPS];
  logic [TAG_W-1:0]   tag_q [OPS];
  logic [TAG_W-1:0]   tag_d [OPS];
  logic [2*WIDTH-1:0] prod_q, prod_d;
  logic [TAG_W-1:0]   otag_q, otag_d;

  logic               stall;
  logic               sgn_in;
  logic [2*WIDTH-1:0] a_ext, b_ext;

`ifdef MULT_PIPE_VR_SIGNED_EN
  assign sgn_in = in_signed;
`else
  // Signed mode disabled: the port stays for a uniform interface but has no effect.
  logic unused_in_signed;
  assign unused_in_signed = in_signed;
  assign sgn_in           = 1'b0;
`endif

  // Extending both operands to 2*WIDTH (sign or zero) makes the truncated
  // 2*WIDTH product exact in either mode.
  always_comb begin
    if (sgn_q[OPS-1]) begin
      a_ext = {{WIDTH{a_q[OPS-1][WIDTH-1]}}, a_q[OPS-1]};
      b_ext = {{WIDTH{b_q[OPS-1][WIDTH-1]}}, b_q[OPS-1]};
    end else begin
      a_ext = {{WIDTH{1'b0}}, a_q[OPS-1]};
      b_ext = {{WIDTH{1'b0}}, b_q[OPS-1]};
    end
  end

  always_comb begin
    stall  = vld_q[LAT-1] && !out_ready;
    vld_d  = vld_q;
    a_d    = a_q;
    b_d    = b_q;
    sgn_d  = sgn_q;
    tag_d  = tag_q;
    prod_d = prod_q;
    otag_d = otag_q;
    if (!stall) begin
      // in_ready == !stall here, so in_valid alone means an accept.
      vld_d[0] = in_valid;
      a_d[0]   = in_valid ? multiplicand : '0;
      b_d[0]   = in_valid ? multiplier   : '0;
      sgn_d[0] = in_valid ? sgn_in       : 1'b0;
      tag_d[0] = in_valid ? in_tag       : '0;
      for (int unsigned k = 1; k < OPS; k++) begin
        vld_d[k] = vld_q[k-1];
        a_d[k]   = a_q[k-1];
        b_d[k]   = b_q[k-1];
        sgn_d[k] = sgn_q[k-1];
        tag_d[k] = tag_q[k-1];
      end
      // Bubbles load zeros so product/out_tag read 0 whenever out_valid=0.
      vld_d[LAT-1] = vld_q[LAT-2];
      prod_d       = vld_q[LAT-2] ? a_ext * b_ext : '0;
      otag_d       = vld_q[LAT-2] ? tag_q[OPS-1]  : '0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vld_q <= '0;
      for (int unsigned k = 0; k < OPS; k++) begin
        a_q[k]   <= '0;
        b_q[k]   <= '0;
        sgn_q[k] <= 1'b0;
        tag_q[k] <= '0;
      end
      prod_q <= '0;
      otag_q <= '0;
    end else begin
      vld_q  <= vld_d;
      a_q    <= a_d;
      b_q    <= b_d;
      sgn_q  <= sgn_d;
      tag_q  <= tag_d;
      prod_q <= prod_d;
      otag_q <= otag_d;
    end
  end

  assign out_valid = vld_q[LAT-1];
  assign product   = prod_q;
  assign out_tag   = otag_q;
  assign in_ready  = !stall;
  assign busy      = |vld_q;

endmodule

// File: tb/tb_mult_pipe_vr.sv
// Self-checking bench for mult_pipe_vr (WIDTH=32, LAT=3, TAG_W=4).
// Expected results are queued at accept time and compared when the DUT
// hands a result over; a tag-indexed table provides the reference product.
module tb_mult_pipe_vr;

  localparam int WIDTH = 32;
  localparam int LAT   = 3;
  localparam int TAG_W = 4;

  logic                 clk = 1'b0;
  logic                 rst_n;
  logic                 in_valid;
  logic                 in_ready;
  logic [WIDTH-1:0]     multiplicand;
  logic [WIDTH-1:0]     multiplier;
  logic                 in_signed;
  logic [TAG_W-1:0]     in_tag;
  logic                 out_valid;
  logic                 out_ready;
  logic [2*WIDTH-1:0]   product;
  logic [TAG_W-1:0]     out_tag;
  logic                 busy;

  mult_pipe_vr #(.WIDTH(WIDTH), .LAT(LAT), .TAG_W(TAG_W)) dut (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid), .in_ready(in_ready),
    .multiplicand(multiplicand), .multiplier(multiplier),
    .in_signed(in_signed), .in_tag(in_tag),
    .out_valid(out_valid), .out_ready(out_ready),
    .product(product), .out_tag(out_tag), .busy(busy)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [TAG_W-1:0]   tag;
    logic [2*WIDTH-1:0] prod;
  } exp_t;

  exp_t               sb [$];
  int                 out_cyc [$];
  logic [2*WIDTH-1:0] exp_by_tag [16];
  int                 n_chk = 0;
  int                 n_err = 0;
  int                 cyc = 0;
  int                 last_acc = 0;
  logic               rand_rdy = 1'b0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic logic [63:0] ref_mul(input logic [31:0] a, input logic [31:0] b, input logic s);
    logic signed [63:0] sa, sb_;
    logic [63:0]        ua, ub;
    sa = $signed(a);
    sb_ = $signed(b);
    ua = {32'b0, a};
    ub = {32'b0, b};
`ifdef MULT_PIPE_VR_SIGNED_EN
    if (s) return sa * sb_;
`else
    if (s && (sa != sb_)) return ua * ub;  // signed mode unavailable
`endif
    return ua * ub;
  endfunction

  always @(posedge clk) cyc <= cyc + 1;

  // Output monitor: samples on the falling edge, away from the active edge.
  always @(negedge clk) begin
    check("in_ready", in_ready, !(out_valid && !out_ready));
    if (!out_valid) begin
      check("idle_prod", product, 64'h0);
      check("idle_tag", out_tag, 64'h0);
    end else if (out_ready) begin
      if (sb.size() == 0) begin
        check("unexpected_out", 1, 0);
      end else begin
        exp_t e;
        e = sb.pop_front();
        check("out_tag", out_tag, e.tag);
        check("product", product, e.prod);
        check("ref_by_tag", product, exp_by_tag[out_tag]);
        out_cyc.push_back(cyc);
      end
    end
  end

  task automatic send(input logic [31:0] a, input logic [31:0] b, input logic s,
                      input logic [TAG_W-1:0] t, input logic [63:0] exp, output int waits);
    logic rdy;
    int   acc;
    multiplicand = a;
    multiplier   = b;
    in_signed    = s;
    in_tag       = t;
    in_valid     = 1'b1;
    waits        = 0;
    for (int n = 0; n < 50; n++) begin
      if (rand_rdy) out_ready = 1'($urandom_range(0, 1));
      @(negedge clk);
      rdy = in_ready;
      acc = cyc;
      @(posedge clk);
      #1;
      if (rdy) begin
        exp_t e;
        e.tag = t;
        e.prod = exp;
        sb.push_back(e);
        exp_by_tag[t] = exp;
        last_acc = acc;
        in_valid = 1'b0;
        return;
      end
      waits++;
    end
    check("send_timeout", 1, 0);
    in_valid = 1'b0;
  endtask

  task automatic drain();
    logic done;
    done = 1'b0;
    in_valid = 1'b0;
    for (int n = 0; n < 100 && !done; n++) begin
      if (rand_rdy) out_ready = 1'($urandom_range(0, 1));
      @(negedge clk);
      done = (sb.size() == 0) && !busy;
      @(posedge clk);
      #1;
    end
    check("drain_done", done, 1);
  endtask

  initial begin
    int w;
    logic [31:0] ra, rb;
    logic        rs;

    rst_n = 1'b0; in_valid = 1'b0; multiplicand = '0; multiplier = '0;
    in_signed = 1'b0; in_tag = '0; out_ready = 1'b1;
    #1;
    check("rst_out_valid", out_valid, 0);
    check("rst_busy", busy, 0);
    check("rst_in_ready", in_ready, 1);
    check("rst_product", product, 0);
    #21 rst_n = 1'b1;
    @(posedge clk); #1;

    // Directed arithmetic
    send(32'hFFFF_FFFF, 32'h0000_0002, 1'b0, 4'd0, 64'h0000_0001_FFFF_FFFE, w);
    send(32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0, 4'd1, 64'hFFFF_FFFE_0000_0001, w);
    send(32'h8000_0000, 32'h8000_0000, 1'b0, 4'd2, 64'h4000_0000_0000_0000, w);
    send(32'h0000_0000, 32'h1234_5678, 1'b0, 4'd3, 64'h0, w);
`ifdef MULT_PIPE_VR_SIGNED_EN
    send(32'hFFFF_FFFF, 32'h0000_0002, 1'b1, 4'd4, 64'hFFFF_FFFF_FFFF_FFFE, w);
    send(32'h8000_0000, 32'h8000_0000, 1'b1, 4'd5, 64'h4000_0000_0000_0000, w);
`else
    send(32'hFFFF_FFFF, 32'h0000_0002, 1'b1, 4'd4, 64'h0000_0001_FFFF_FFFE, w);
`endif
    drain();

    // Streaming: 10 back-to-back accepts, tags 0..9
    out_cyc.delete();
    begin
      int first_acc;
      first_acc = 0;
      for (int t = 0; t < 10; t++) begin
        ra = $urandom; rb = $urandom;
        send(ra, rb, 1'b0, 4'(t), ref_mul(ra, rb, 1'b0), w);
        check("stream_in_ready", w, 0);
        if (t == 0) first_acc = last_acc;
      end
      drain();
      check("stream_count", out_cyc.size(), 10);
      if (out_cyc.size() == 10) begin
        check("stream_first_lat", out_cyc[0], first_acc + LAT);
        for (int i = 1; i < 10; i++) check("stream_consec", out_cyc[i], out_cyc[0] + i);
      end
    end

    // Backpressure: fill the pipeline, then hold out_ready low for 5 cycles
    out_cyc.delete();
    out_ready = 1'b0;
    send(32'd7,   32'd9,   1'b0, 4'd10, 64'd63, w);
    check("bp_fill0", w, 0);
    send(32'd100, 32'd3,   1'b0, 4'd11, 64'd300, w);
    check("bp_fill1", w, 0);
    send(32'd5,   32'd5,   1'b0, 4'd12, 64'd25, w);
    check("bp_fill2", w, 0);
    multiplicand = 32'd6; multiplier = 32'd8; in_signed = 1'b0; in_tag = 4'd13; in_valid = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      check("bp_in_ready", in_ready, 0);
      check("bp_valid", out_valid, 1);
      check("bp_product", product, 64'd63);
      check("bp_tag", out_tag, 64'd10);
      @(posedge clk); #1;
    end
    out_ready = 1'b1;
    send(32'd6, 32'd8, 1'b0, 4'd13, 64'd48, w);
    drain();
    check("bp_delivered", out_cyc.size(), 4);

    // Random mix with random backpressure
    rand_rdy = 1'b1;
    for (int i = 0; i < 30; i++) begin
      ra = $urandom; rb = $urandom; rs = 1'($urandom_range(0, 1));
      if (i % 5 == 0) ra = 32'h8000_0000;
      send(ra, rb, rs, 4'(i % 16), ref_mul(ra, rb, rs), w);
    end
    drain();
    rand_rdy = 1'b0;
    out_ready = 1'b1;

    // Reset with two operations in flight
    send(32'd11, 32'd13, 1'b0, 4'd14, 64'd143, w);
    send(32'd17, 32'd19, 1'b0, 4'd15, 64'd323, w);
    #3 rst_n = 1'b0;
    #1;
    check("mrst_out_valid", out_valid, 0);
    check("mrst_busy", busy, 0);
    check("mrst_in_ready", in_ready, 1);
    check("mrst_product", product, 0);
    check("mrst_tag", out_tag, 0);
    sb.delete();
    out_cyc.delete();
    @(posedge clk);
    #3 rst_n = 1'b1;
    send(32'd21, 32'd2, 1'b0, 4'd9, 64'd42, w);
    check("post_rst_first_accept", w, 0);
    drain();
    check("post_rst_count", out_cyc.size(), 1);
    if (out_cyc.size() == 1) check("post_rst_lat", out_cyc[0], last_acc + LAT);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule

// File: doc/mult_pipe_vr.md
MULT_PIPE_VR -- requirements
Module: mult_pipe_vr

Interface
REQ-001 SHALL provide parameter WIDTH, default 32: operand width in bits, legal range 4..64.
REQ-002 SHALL provide parameter LAT, default 2: accept-to-result latency in cycles, legal range 2..8.
REQ-003 SHALL provide parameter TAG_W, default 4: width of the sideband tag carried with each operation, legal range 1..16.
REQ-004 clk  in  1  single clock; all state updates on its rising edge.
REQ-005 rst_n  in  1  reset, asynchronous, active-low.
REQ-006 in_valid  in  1  operand pair offered.
REQ-007 in_ready  out  1  operand pair can be accepted.
REQ-008 multiplicand  in  WIDTH  operand A.
REQ-009 multiplier  in  WIDTH  operand B.
REQ-010 in_signed  in  1  1 selects a two's-complement multiply; 0 selects unsigned.
REQ-011 in_tag  in  TAG_W  sideband value returned with the product.
REQ-012 out_valid  out  1  product available.
REQ-013 out_ready  in  1  downstream accepts the product.
REQ-014 product  out  2*WIDTH  full-width product.
REQ-015 out_tag  out  TAG_W  tag of the operation currently in product.
REQ-016 busy  out  1  high when any pipeline stage holds a valid operation.

Function
REQ-017 Accept SHALL occur on a rising edge where in_valid && in_ready; no other condition accepts an operation.
REQ-018 Pipeline SHALL have LAT stages, each holding a valid bit, payload and tag; stage 1 captures the accepted operands, and the multiply result is registered by stage LAT.
REQ-019 Without a stall, an operation accepted at edge N SHALL present out_valid=1 with its product and tag after edge N+LAT-1, i.e. LAT cycles after its in_valid cycle.
REQ-020 A stall SHALL be defined as out_valid && !out_ready; during a stall all stages hold their contents, and in_ready = !stall (combinational from out_ready and the last-stage valid bit).
REQ-021 Bubbles SHALL propagate when there is no stall; valid bits advance every non-stalled cycle, so back-to-back accepts give a throughput of one result per cycle.
REQ-022 Results SHALL leave in strict accept order; the pipeline SHALL NOT drop, duplicate or reorder operations.
REQ-023 product, out_tag and the sign mode SHALL remain stable while out_valid && !out_ready.
REQ-024 When in_signed=0, product SHALL equal A*B with both operands zero-extended to 2*WIDTH, exact with no truncation.
REQ-025 Signed-mode arithmetic SHALL follow REQ-037/REQ-038.
REQ-026 busy SHALL be the OR of all stage valid bits.
REQ-027 product and out_tag SHALL be 0 whenever out_valid=0.

Reset
REQ-028 Asserting rst_n=0 SHALL immediately clear all valid bits, payloads and tags, regardless of the clock.
REQ-029 During reset the outputs SHALL be out_valid=0, product=0, out_tag=0, busy=0, in_ready=1.
REQ-030 Operations in flight when reset is asserted SHALL be discarded; no result emerges after release.
REQ-031 The first accept SHALL be permitted on the first rising edge after rst_n deasserts.

Configuration
REQ-032 Macro MULT_PIPE_VR_SIGNED_EN SHALL control signed-multiply support.
REQ-033 With MULT_PIPE_VR_SIGNED_EN defined, in_signed SHALL be sampled at accept and carried down the pipeline with the operation.
REQ-034 With MULT_PIPE_VR_SIGNED_EN undefined, the in_signed port SHALL still exist but be ignored, and all operations SHALL be unsigned.
REQ-035 The port list SHALL be identical in both builds.

Verification
REQ-036 Every bench SHALL check each result against a reference model indexed by tag, and SHALL cover the directed scenarios REQ-037 to REQ-041.
REQ-037 Signed arithmetic, build with MULT_PIPE_VR_SIGNED_EN, WIDTH=32, in_signed=1: A=0xFFFFFFFF, B=0x00000002 -> product=0xFFFFFFFFFFFFFFFE; A=0x80000000, B=0x80000000 -> product=0x4000000000000000.
REQ-038 Unsigned fallback, build without MULT_PIPE_VR_SIGNED_EN: A=0xFFFFFFFF, B=0x00000002, in_signed=1 -> product=0x00000001FFFFFFFE.
REQ-039 Streaming, WIDTH=32, LAT=3, out_ready=1: 10 back-to-back accepts with tags 0..9 -> out_valid high for 10 consecutive cycles starting 3 cycles after the first accept; tags emerge 0..9 in order; in_ready stays 1 throughout.
REQ-040 Backpressure: hold out_ready=0 for 5 cycles with the pipeline full -> in_ready=0 and product/out_tag stable for those 5 cycles; after release, every result is delivered once, in order, with no loss.
REQ-041 Reset mid-operation: 2 operations in flight, pull rst_n low between clock edges -> out_valid=0 and busy=0 immediately; no stale result appears after release; a new accept produces a correct result LAT cycles later.
